// File: rtl/audio_sched_pkg.sv
// Shared definitions for the audio event scheduler: sample-ID width,
// sample-ID and priority constants, and a small width helper.
package audio_sched_pkg;

  localparam int SAMPLE_ID_BITS = 4;
  localparam int PRIO_ID_BITS   = 2;

  localparam logic [SAMPLE_ID_BITS-1:0] SAMPLE_WALL      = 4'd1;
  localparam logic [SAMPLE_ID_BITS-1:0] SAMPLE_PADDLE    = 4'd2;
  localparam logic [SAMPLE_ID_BITS-1:0] SAMPLE_BLOCK     = 4'd3;
  localparam logic [SAMPLE_ID_BITS-1:0] SAMPLE_LOST_BALL = 4'd4;
  localparam logic [SAMPLE_ID_BITS-1:0] SAMPLE_CHIME     = 4'd5;

  localparam logic [PRIO_ID_BITS-1:0] PRIO_LOST_BALL = 2'd3;
  localparam logic [PRIO_ID_BITS-1:0] PRIO_BLOCK     = 2'd2;
  localparam logic [PRIO_ID_BITS-1:0] PRIO_PADDLE    = 2'd1;
  localparam logic [PRIO_ID_BITS-1:0] PRIO_WALL      = 2'd0;

  // Counter width that stays at least one bit for tiny or zero ranges.
  function automatic int unsigned min_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/audio_pending_queue.sv
// Age-ordered pending queue for sound requests: merge / insert / replace / drop
// on enqueue, and highest-priority-oldest selection for dequeue.
module audio_pending_queue
  import audio_sched_pkg::*;
#(
  parameter int SAMPLE_BITS = SAMPLE_ID_BITS,
  parameter int PRIO_BITS   = PRIO_ID_BITS,
  parameter int DEPTH       = 4,
  localparam int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                   CLK,
  input  logic                   RESET_N,
  input  logic                   req_valid,
  input  logic [SAMPLE_BITS-1:0] req_sample,
  input  logic [PRIO_BITS-1:0]   req_prio,
  input  logic                   deq_en,
  output logic [SAMPLE_BITS-1:0] sel_sample,
  output logic [PRIO_BITS-1:0]   sel_prio,
  output logic                   not_empty,
  output logic [CNT_W-1:0]       count,
  output logic                   dropped
);

  localparam int IDX_W = $clog2(DEPTH);

  // Slots 0..q_count-1 are valid; slot 0 is the oldest entry.
  logic [SAMPLE_BITS-1:0] q_sample   [DEPTH];
  logic [PRIO_BITS-1:0]   q_prio     [DEPTH];
  logic [CNT_W-1:0]       q_count;

  logic [SAMPLE_BITS-1:0] mid_sample [DEPTH];
  logic [PRIO_BITS-1:0]   mid_prio   [DEPTH];
  logic [CNT_W-1:0]       mid_count;
  logic [SAMPLE_BITS-1:0] nxt_sample [DEPTH];
  logic [PRIO_BITS-1:0]   nxt_prio   [DEPTH];
  logic [CNT_W-1:0]       nxt_count;

  logic [IDX_W-1:0]       sel_idx, hit_idx, vic_idx;
  logic                   deq, hit, full, drop_c;
  logic [PRIO_BITS-1:0]   vic_prio;

  // NOTE: every variable written here gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    sel_idx = '0;
    for (int i = 1; i < DEPTH; i++)
      if (CNT_W'(i) < q_count && q_prio[i] > q_prio[sel_idx]) sel_idx = IDX_W'(i);

    deq        = deq_en && (q_count != '0);
    mid_sample = q_sample;
    mid_prio   = q_prio;
    mid_count  = q_count - CNT_W'(deq);
    // The dequeued entry is squeezed out before enqueue, so it can never be a merge or replace target.
    for (int i = 0; i < DEPTH - 1; i++)
      if (deq && IDX_W'(i) >= sel_idx) begin
        mid_sample[i] = q_sample[i+1];
        mid_prio[i]   = q_prio[i+1];
      end

    hit      = 1'b0;
    hit_idx  = '0;
    vic_idx  = '0;
    vic_prio = mid_prio[0];
    for (int i = 0; i < DEPTH; i++)
      if (CNT_W'(i) < mid_count) begin
        if (mid_sample[i] == req_sample) begin
          hit     = 1'b1;
          hit_idx = IDX_W'(i);
        end
        if (mid_prio[i] <= vic_prio) begin
          vic_prio = mid_prio[i];
          vic_idx  = IDX_W'(i);
        end
      end
    full = (mid_count == CNT_W'(DEPTH));

    nxt_sample = mid_sample;
    nxt_prio   = mid_prio;
    nxt_count  = mid_count;
    drop_c     = 1'b0;
    if (req_valid) begin
      if (hit) begin
        if (req_prio > mid_prio[hit_idx]) nxt_prio[hit_idx] = req_prio;
      end else if (!full) begin
        for (int i = 0; i < DEPTH; i++)
          if (CNT_W'(i) == mid_count) begin
            nxt_sample[i] = req_sample;
            nxt_prio[i]   = req_prio;
          end
        nxt_count = mid_count + 1'b1;
      end else begin
        drop_c = 1'b1;
        // Victim is removed and the newcomer appended as the youngest entry.
        if (req_prio > vic_prio) begin
          for (int i = 0; i < DEPTH - 1; i++)
            if (IDX_W'(i) >= vic_idx) begin
              nxt_sample[i] = mid_sample[i+1];
              nxt_prio[i]   = mid_prio[i+1];
            end
          nxt_sample[DEPTH-1] = req_sample;
          nxt_prio[DEPTH-1]   = req_prio;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      q_count <= '0;
      dropped <= 1'b0;
    end else begin
      q_count <= nxt_count;
      dropped <= drop_c;
    end
  end

  // NOTE: storage is deliberately not reset; slots at or above q_count are never treated as valid.
  always_ff @(posedge CLK) begin
    q_sample <= nxt_sample;
    q_prio   <= nxt_prio;
  end

  assign sel_sample = q_sample[sel_idx];
  assign sel_prio   = q_prio[sel_idx];
  assign not_empty  = (q_count != '0);
  assign count      = q_count;

endmodule

// File: rtl/audio_event_scheduler.sv
// Sound-effect scheduler: pending queue plus playback FSM and guard-gap counter.
// Optional preemption of the playing sample is built with AUDIO_SCHED_PREEMPT_EN.
module audio_event_scheduler
  import audio_sched_pkg::*;
#(
  parameter int SAMPLE_BITS = SAMPLE_ID_BITS,
  parameter int PRIO_BITS   = PRIO_ID_BITS,
  parameter int DEPTH       = 4,
  parameter int GAP_CYCLES  = 16
) (
  input  logic                         CLK,
  input  logic                         RESET_N,
  input  logic                         REQ_VALID,
  input  logic [SAMPLE_BITS-1:0]       REQ_SAMPLE,
  input  logic [PRIO_BITS-1:0]         REQ_PRIO,
  output logic                         REQ_DROPPED,
  output logic                         PLAY_START,
  output logic [SAMPLE_BITS-1:0]       PLAY_SAMPLE,
  input  logic                         PLAYER_BUSY,
  output logic                         PLAY_ABORT,
  output logic [$clog2(DEPTH+1)-1:0]   PENDING_COUNT,
  output logic                         ACTIVE
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int GAP_W = min_width(GAP_CYCLES);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START     = 3'd1;
  localparam logic [2:0] ST_WAIT_BUSY = 3'd2;
  localparam logic [2:0] ST_PLAYING   = 3'd3;
  localparam logic [2:0] ST_GAP       = 3'd4;
`ifdef AUDIO_SCHED_PREEMPT_EN
  localparam logic [2:0] ST_ABORT     = 3'd5;
`endif

  logic [2:0]             state;
  logic [GAP_W-1:0]       gap_cnt;
  logic [SAMPLE_BITS-1:0] play_sample;
  logic                   q_req_valid, deq_en, q_not_empty, q_dropped, preempt;
  logic [SAMPLE_BITS-1:0] q_sel_sample;
  logic [PRIO_BITS-1:0]   q_sel_prio;
  logic [CNT_W-1:0]       q_count;

`ifdef AUDIO_SCHED_PREEMPT_EN
  logic [PRIO_BITS-1:0]   play_prio;
  assign preempt = REQ_VALID && (REQ_PRIO > play_prio) &&
                   (state == ST_WAIT_BUSY || state == ST_PLAYING || state == ST_GAP);
`else
  logic unused_sel_prio;
  assign unused_sel_prio = ^q_sel_prio;
  assign preempt         = 1'b0;
`endif

  // A preempting request bypasses the queue entirely.
  assign q_req_valid = REQ_VALID && !preempt;
  assign deq_en      = (state == ST_IDLE) && q_not_empty;

  audio_pending_queue #(
    .SAMPLE_BITS (SAMPLE_BITS),
    .PRIO_BITS   (PRIO_BITS),
    .DEPTH       (DEPTH)
  ) u_queue (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .req_valid  (q_req_valid),
    .req_sample (REQ_SAMPLE),
    .req_prio   (REQ_PRIO),
    .deq_en     (deq_en),
    .sel_sample (q_sel_sample),
    .sel_prio   (q_sel_prio),
    .not_empty  (q_not_empty),
    .count      (q_count),
    .dropped    (q_dropped)
  );

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state       <= ST_IDLE;
      play_sample <= '0;
      gap_cnt     <= '0;
`ifdef AUDIO_SCHED_PREEMPT_EN
      play_prio   <= '0;
`endif
    end
`ifdef AUDIO_SCHED_PREEMPT_EN
    // Abort gets its own cycle so the player never sees stop and start together.
    else if (preempt) begin
      state       <= ST_ABORT;
      play_sample <= REQ_SAMPLE;
      play_prio   <= REQ_PRIO;
    end
`endif
    else begin
      case (state)
        ST_IDLE:
          if (q_not_empty) begin
            state       <= ST_START;
            play_sample <= q_sel_sample;
`ifdef AUDIO_SCHED_PREEMPT_EN
            play_prio   <= q_sel_prio;
`endif
          end
        ST_START:     state <= ST_WAIT_BUSY;
        ST_WAIT_BUSY: if (PLAYER_BUSY) state <= ST_PLAYING;
        ST_PLAYING:
          if (!PLAYER_BUSY) begin
            state   <= (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
            gap_cnt <= '0;
          end
        ST_GAP:
          if (gap_cnt == GAP_LAST) state <= ST_IDLE;
          else gap_cnt <= gap_cnt + 1'b1;
`ifdef AUDIO_SCHED_PREEMPT_EN
        ST_ABORT:     state <= ST_START;
`endif
        default:      state <= ST_IDLE;
      endcase
    end
  end

`ifdef AUDIO_SCHED_PREEMPT_EN
  assign PLAY_ABORT = (state == ST_ABORT);
`else
  assign PLAY_ABORT = 1'b0;
`endif

  assign PLAY_START    = (state == ST_START);
  assign PLAY_SAMPLE   = play_sample;
  assign PENDING_COUNT = q_count;
  assign REQ_DROPPED   = q_dropped;
  assign ACTIVE        = (state != ST_IDLE);

endmodule

// File: doc/audio_event_scheduler.md
# audio_event_scheduler

Queues and sequences sound-effect requests from the game logic onto the single sample player. Sits between the game controller, which raises one request per physics step, and the sample playback engine. Keeps a small priority queue so that simultaneous events (block hit plus wall bounce, lost ball during a chime) are played in order rather than overwriting each other. Enforces a guard gap between consecutive samples.

## Interface
- SAMPLE_BITS, 4, width of a sample index (matches the shared sample-ID width)
- PRIO_BITS, 2, request priority width; larger value means more urgent
- DEPTH, 4, pending-queue entries (2..8)
- GAP_CYCLES, 16, idle cycles enforced after a sample ends (0 allowed)
- CLK  in  1  system clock; all logic on rising edge
- RESET_N  in  1  synchronous reset, active-low
- REQ_VALID  in  1  one-cycle request strobe
- REQ_SAMPLE  in  SAMPLE_BITS  sample to play
- REQ_PRIO  in  PRIO_BITS  request priority
- REQ_DROPPED  out  1  one-cycle pulse: request discarded
- PLAY_START  out  1  one-cycle pulse to player
- PLAY_SAMPLE  out  SAMPLE_BITS  sample index, held from PLAY_START until next start
- PLAYER_BUSY  in  1  high while the player outputs a sample
- PLAY_ABORT  out  1  one-cycle stop pulse (constant 0 unless preemption compiled in)
- PENDING_COUNT  out  $clog2(DEPTH+1)  valid queue entries
- ACTIVE  out  1  high in every state except IDLE

## Operation
- Reset (RESET_N low at an edge): queue emptied, state IDLE. All outputs 0: REQ_DROPPED, PLAY_START, PLAY_SAMPLE, PLAY_ABORT, PENDING_COUNT, ACTIVE. Applies mid-play; no abort pulse is issued.
- Enqueue on REQ_VALID, in precedence order:
  - Merge: if REQ_SAMPLE is already pending, the entry's priority becomes max(old, new). Its age is kept. No drop, count unchanged.
  - Insert: if free slot (count after this cycle's dequeue < DEPTH), the new entry is the youngest.
  - Replace: if full and REQ_PRIO > lowest pending priority, the youngest entry of lowest priority is overwritten. REQ_DROPPED pulses (victim lost).
  - Drop: otherwise REQ_DROPPED pulses; queue unchanged.
- Dequeue selection: highest priority, oldest among equals.
- FSM:
  - IDLE -> START when queue non-empty. Dequeue the selected entry and latch it into PLAY_SAMPLE and the playing priority.
  - START: PLAY_START=1 for one cycle -> WAIT_BUSY.
  - WAIT_BUSY -> PLAYING when PLAYER_BUSY=1.
  - PLAYING -> GAP when PLAYER_BUSY=0. If GAP_CYCLES=0, go to IDLE instead.
  - GAP: counter runs GAP_CYCLES cycles -> IDLE.
- The queue accepts requests in every state.

## Timing
- Request at edge N into an empty, idle block: entry visible at N+1 (PENDING_COUNT=1, IDLE). Dequeue and PLAY_SAMPLE update at N+2, PLAY_START high during cycle N+2..N+3. Request-to-start latency is 2 cycles.
- Back-to-back: PLAYER_BUSY falls at edge M. The next PLAY_START asserts at M+GAP_CYCLES+2.
- Enqueue and dequeue in the same cycle are both honoured. The entry being dequeued cannot be merge or replace target.
- REQ_DROPPED is registered: it asserts the cycle after the offending request.

## Configuration
- AUDIO_SCHED_PREEMPT_EN defined:
  - Applies in WAIT_BUSY, PLAYING or GAP, when REQ_VALID has REQ_PRIO strictly greater than the playing priority.
  - Next cycle: PLAY_ABORT pulses, PLAY_SAMPLE/priority load the request, state goes to START. The gap is skipped.
  - The preempting request bypasses the queue. The aborted sample is discarded, not re-queued.
- Undefined: PLAY_ABORT tied 0; all requests go through the queue.

## Structure
- Shared package/include: sample-ID width, sample-ID constants, priority constants (lost ball 3, block 2, paddle 1, wall 0).
- Sub-module audio_pending_queue holds:
  - storage and age ordering
  - merge/insert/replace/drop logic
  - selection
- The top level holds the FSM and gap counter.

## Test plan
- Single request (sample 5, prio 1) at edge 10 -> PLAY_START at 12, PLAY_SAMPLE=5, PENDING_COUNT back to 0 at 12.
- Requests wall(prio 0), block(prio 2), paddle(prio 1) while a sample plays -> played in order block, paddle, wall, each start GAP_CYCLES+2 after previous BUSY fall.
- Fill DEPTH=4 with prio 1; request prio 0 -> REQ_DROPPED, queue unchanged. Then request prio 3 -> REQ_DROPPED, youngest prio-1 entry replaced.
- Duplicate sample 7 prio 0 then prio 2 -> one entry, priority 2, no drop.
- Reset asserted mid-PLAYING with 3 pending -> next cycle all outputs 0, ACTIVE 0, no PLAY_START until new request.
- With AUDIO_SCHED_PREEMPT_EN, prio 3 request during prio 1 playback -> PLAY_ABORT next cycle, PLAY_START one cycle later with new sample, queue untouched. Without the macro, the same request is queued and PLAY_ABORT stays 0.
